up_down_counter_mod: RTL and testbench

//   Parametrised synchronous up/down binary counter with programmable modulus,

---
 rtl/up_down_counter_mod_if.sv | 39 +++
 rtl/up_down_counter_mod.sv | 93 +++++++++
 tb/tb_up_down_counter_mod.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_mod_if.sv
// rtl/up_down_counter_mod_if.sv - control/status bundle for the up/down counter
//
// Purpose: groups the counter's request inputs and count/flag outputs so the
// counter and its user connect through one port.
// Signals:
//   clr     master->slave  synchronous clear request
//   load    master->slave  synchronous parallel load request
//   d       master->slave  load value (WIDTH bits)
//   up      master->slave  count-up request
//   down    master->slave  count-down request
//   count   slave->master  registered count (WIDTH bits)
//   max_tc  slave->master  count == MODULUS-1 decode
//   min_tc  slave->master  count == 0 decode
//   carry   slave->master  one-cycle up-wrap/up-saturation pulse
//   borrow  slave->master  one-cycle down-wrap/down-saturation pulse
interface up_down_counter_mod_if #(
    parameter int WIDTH = 4
) ();
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             max_tc;
    logic             min_tc;
    logic             carry;
    logic             borrow;

    modport master (
        output clr, load, d, up, down,
        input  count, max_tc, min_tc, carry, borrow
    );

    modport slave (
        input  clr, load, d, up, down,
        output count, max_tc, min_tc, carry, borrow
    );
endinterface

// File: rtl/up_down_counter_mod.sv
// rtl/up_down_counter_mod.sv - parametrised up/down counter with modulus, wrap/saturate, clear, load
//
// Purpose: event/position counter over 0..MODULUS-1. Per clock edge the
// request priority is clr > load > up > down > hold. At a bound the counter
// either wraps (SATURATE=0) or holds (SATURATE=1); either way the bound event
// is flagged with a one-cycle carry (up) or borrow (down) pulse that is
// registered alongside the updated count.
// Parameters:
//   WIDTH     counter width in bits (>= 1)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE  0 = wrap at bounds, 1 = hold at bounds
// Ports:
//   clk_i   rising-edge clock
//   rstn_i  asynchronous active-low reset (count/carry/borrow to 0)
//   bus     slave side of up_down_counter_mod_if (requests in, count/flags out)
module up_down_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    up_down_counter_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_CNT};

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH:0]   d_ext;
    logic             at_max;
    logic             at_min;

    // Load value is compared one bit wider so MODULUS = 2**WIDTH never
    // clamps and any d >= MODULUS clamps to the top of the range.
    assign d_ext  = {1'b0, bus.d};
    assign at_max = (count_q == MAX_CNT);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            if (d_ext > MAX_EXT) begin
                count_d = MAX_CNT;
            end else begin
                count_d = bus.d;
            end
        end else if (bus.up) begin
            // up wins over a simultaneous down request
            if (at_max) begin
                carry_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (bus.down) begin
            if (at_min) begin
                borrow_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = MAX_CNT;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.max_tc = at_max;
    assign bus.min_tc = at_min;
    assign bus.carry  = carry_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_up_down_counter_mod.sv
// tb/tb_up_down_counter_mod.sv - self-checking bench for up_down_counter_mod
module tb_up_down_counter_mod;
    localparam int NCFG = 5;

    logic       clk;
    logic       rstn;
    logic       clr, load, up, down;
    logic [3:0] d;

    int total = 0;
    int bad   = 0;

    // configurations: a=4/16/0 b=4/10/0 c=4/16/1 d=1/2/0 e=1/2/1
    int cfg_w   [NCFG] = '{4, 4, 4, 1, 1};
    int cfg_mod [NCFG] = '{16, 10, 16, 2, 2};
    int cfg_sat [NCFG] = '{0, 0, 1, 0, 1};

    // reference model state
    int m_cnt [NCFG];
    int m_cy  [NCFG];
    int m_bw  [NCFG];

    up_down_counter_mod_if #(.WIDTH(4)) if_a ();
    up_down_counter_mod_if #(.WIDTH(4)) if_b ();
    up_down_counter_mod_if #(.WIDTH(4)) if_c ();
    up_down_counter_mod_if #(.WIDTH(1)) if_d ();
    up_down_counter_mod_if #(.WIDTH(1)) if_e ();

    assign if_a.clr = clr;  assign if_a.load = load;  assign if_a.up = up;  assign if_a.down = down;  assign if_a.d = d;
    assign if_b.clr = clr;  assign if_b.load = load;  assign if_b.up = up;  assign if_b.down = down;  assign if_b.d = d;
    assign if_c.clr = clr;  assign if_c.load = load;  assign if_c.up = up;  assign if_c.down = down;  assign if_c.d = d;
    assign if_d.clr = clr;  assign if_d.load = load;  assign if_d.up = up;  assign if_d.down = down;  assign if_d.d = d[0];
    assign if_e.clr = clr;  assign if_e.load = load;  assign if_e.up = up;  assign if_e.down = down;  assign if_e.d = d[0];

    up_down_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(if_a));
    up_down_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(if_b));
    up_down_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) dut_c (.clk_i(clk), .rstn_i(rstn), .bus(if_c));
    up_down_counter_mod #(.WIDTH(1), .MODULUS(2),  .SATURATE(0)) dut_d (.clk_i(clk), .rstn_i(rstn), .bus(if_d));
    up_down_counter_mod #(.WIDTH(1), .MODULUS(2),  .SATURATE(1)) dut_e (.clk_i(clk), .rstn_i(rstn), .bus(if_e));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < NCFG; i++) begin
            m_cnt[i] = 0;
            m_cy[i]  = 0;
            m_bw[i]  = 0;
        end
    endtask

    // Behaviour of one clock edge, taken straight from the rules: priority
    // list, range 0..MOD-1, wrap or hold at the ends with an event pulse.
    task automatic model_edge();
        for (int i = 0; i < NCFG; i++) begin
            int dv;
            dv = int'(d) % (1 << cfg_w[i]);
            m_cy[i] = 0;
            m_bw[i] = 0;
            if (!rstn) begin
                m_cnt[i] = 0;
            end else if (clr) begin
                m_cnt[i] = 0;
            end else if (load) begin
                m_cnt[i] = (dv < cfg_mod[i]) ? dv : cfg_mod[i] - 1;
            end else if (up) begin
                if (m_cnt[i] == cfg_mod[i] - 1) begin
                    m_cy[i] = 1;
                    if (cfg_sat[i] == 0) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else if (down) begin
                if (m_cnt[i] == 0) begin
                    m_bw[i] = 1;
                    if (cfg_sat[i] == 0) m_cnt[i] = cfg_mod[i] - 1;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    // advance one edge; outputs are stable 1 ns later
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic u, input logic dn, input logic [3:0] dv);
        clr = c; load = l; up = u; down = dn; d = dv;
    endtask

    task automatic read_dut(input int i, output int cnt, output int cy, output int bw, output int mx, output int mn);
        case (i)
            0: begin cnt = int'(if_a.count); cy = int'(if_a.carry); bw = int'(if_a.borrow); mx = int'(if_a.max_tc); mn = int'(if_a.min_tc); end
            1: begin cnt = int'(if_b.count); cy = int'(if_b.carry); bw = int'(if_b.borrow); mx = int'(if_b.max_tc); mn = int'(if_b.min_tc); end
            2: begin cnt = int'(if_c.count); cy = int'(if_c.carry); bw = int'(if_c.borrow); mx = int'(if_c.max_tc); mn = int'(if_c.min_tc); end
            3: begin cnt = int'(if_d.count); cy = int'(if_d.carry); bw = int'(if_d.borrow); mx = int'(if_d.max_tc); mn = int'(if_d.min_tc); end
            default: begin cnt = int'(if_e.count); cy = int'(if_e.carry); bw = int'(if_e.borrow); mx = int'(if_e.max_tc); mn = int'(if_e.min_tc); end
        endcase
    endtask

    task automatic test_reset();
        set_in(0, 0, 1, 0, 4'd0);
        rstn = 1'b1;
        #1 rstn = 1'b0;
        model_reset();
        repeat (3) tick();
        total++; if (if_a.count !== 4'd0) begin bad++; $display("FAIL reset_hold_count: got %0d want 0", if_a.count); end
        total++; if (if_a.carry !== 1'b0) begin bad++; $display("FAIL reset_hold_carry: got %0d want 0", if_a.carry); end
        total++; if (if_a.borrow !== 1'b0) begin bad++; $display("FAIL reset_hold_borrow: got %0d want 0", if_a.borrow); end
        total++; if (if_a.min_tc !== 1'b1 || if_a.max_tc !== 1'b0) begin bad++; $display("FAIL reset_flags: got min=%0d max=%0d want min=1 max=0", if_a.min_tc, if_a.max_tc); end
        rstn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (int'(if_a.count) !== k) begin bad++; $display("FAIL reset_release_count%0d: got %0d want %0d", k, if_a.count, k); end
        end
        repeat (4) tick();
        total++; if (if_a.count !== 4'd7) begin bad++; $display("FAIL reset_count7: got %0d want 7", if_a.count); end
        #2 rstn = 1'b0;
        model_reset();
        #1;
        total++; if (if_a.count !== 4'd0) begin bad++; $display("FAIL reset_async: got %0d want 0", if_a.count); end
        tick();
        set_in(0, 0, 0, 0, 4'd0);
        rstn = 1'b1;
        tick();
        total++; if (if_a.count !== 4'd0 || if_a.carry !== 1'b0 || if_a.borrow !== 1'b0) begin bad++; $display("FAIL reset_release_quiet: got cnt=%0d cy=%0d bw=%0d want 0/0/0", if_a.count, if_a.carry, if_a.borrow); end
    endtask

    task automatic test_wrap();
        set_in(0, 1, 0, 0, 4'd14);
        tick();
        total++; if (if_a.count !== 4'd14) begin bad++; $display("FAIL wrap_load14: got %0d want 14", if_a.count); end
        set_in(0, 0, 1, 0, 4'd0);
        tick();
        total++; if (if_a.count !== 4'd15 || if_a.max_tc !== 1'b1 || if_a.carry !== 1'b0) begin bad++; $display("FAIL wrap_15: got cnt=%0d max=%0d cy=%0d want 15/1/0", if_a.count, if_a.max_tc, if_a.carry); end
        tick();
        total++; if (if_a.count !== 4'd0 || if_a.carry !== 1'b1) begin bad++; $display("FAIL wrap_0: got cnt=%0d cy=%0d want 0/1", if_a.count, if_a.carry); end
        tick();
        total++; if (if_a.count !== 4'd1 || if_a.carry !== 1'b0) begin bad++; $display("FAIL wrap_1: got cnt=%0d cy=%0d want 1/0", if_a.count, if_a.carry); end
        set_in(0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_down_priority();
        set_in(1, 0, 0, 0, 4'd0);
        tick();
        total++; if (if_a.min_tc !== 1'b1) begin bad++; $display("FAIL down_min_tc: got %0d want 1", if_a.min_tc); end
        set_in(0, 0, 0, 1, 4'd0);
        tick();
        total++; if (if_a.count !== 4'd15 || if_a.borrow !== 1'b1 || if_a.carry !== 1'b0) begin bad++; $display("FAIL down_wrap: got cnt=%0d bw=%0d cy=%0d want 15/1/0", if_a.count, if_a.borrow, if_a.carry); end
        set_in(0, 1, 0, 0, 4'd5);
        tick();
        set_in(0, 0, 1, 1, 4'd0);
        tick();
        total++; if (if_a.count !== 4'd6 || if_a.borrow !== 1'b0 || if_a.carry !== 1'b0) begin bad++; $display("FAIL down_up_wins: got cnt=%0d bw=%0d cy=%0d want 6/0/0", if_a.count, if_a.borrow, if_a.carry); end
        set_in(0, 0, 0, 0, 4'd0);
        repeat (2) tick();
        total++; if (if_a.count !== 4'd6 || if_a.borrow !== 1'b0 || if_a.carry !== 1'b0) begin bad++; $display("FAIL down_hold: got cnt=%0d bw=%0d cy=%0d want 6/0/0", if_a.count, if_a.borrow, if_a.carry); end
    endtask

    task automatic test_modulus();
        set_in(0, 1, 0, 0, 4'd9);
        tick();
        total++; if (if_b.count !== 4'd9 || if_b.max_tc !== 1'b1) begin bad++; $display("FAIL mod_load9: got cnt=%0d max=%0d want 9/1", if_b.count, if_b.max_tc); end
        set_in(0, 0, 1, 0, 4'd0);
        tick();
        total++; if (if_b.count !== 4'd0 || if_b.carry !== 1'b1) begin bad++; $display("FAIL mod_wrap: got cnt=%0d cy=%0d want 0/1", if_b.count, if_b.carry); end
        set_in(0, 1, 0, 0, 4'd12);
        tick();
        total++; if (if_b.count !== 4'd9 || if_b.carry !== 1'b0) begin bad++; $display("FAIL mod_clamp: got cnt=%0d cy=%0d want 9/0", if_b.count, if_b.carry); end
        set_in(1, 0, 0, 0, 4'd0);
        tick();
        set_in(0, 0, 0, 1, 4'd0);
        tick();
        total++; if (if_b.count !== 4'd9 || if_b.borrow !== 1'b1) begin bad++; $display("FAIL mod_down_wrap: got cnt=%0d bw=%0d want 9/1", if_b.count, if_b.borrow); end
        set_in(0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_saturate();
        set_in(0, 1, 0, 0, 4'd15);
        tick();
        set_in(0, 0, 1, 0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (if_c.count !== 4'd15 || if_c.carry !== 1'b1) begin bad++; $display("FAIL sat_up%0d: got cnt=%0d cy=%0d want 15/1", k, if_c.count, if_c.carry); end
        end
        set_in(1, 0, 0, 0, 4'd0);
        tick();
        set_in(0, 0, 0, 1, 4'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (if_c.count !== 4'd0 || if_c.borrow !== 1'b1) begin bad++; $display("FAIL sat_down%0d: got cnt=%0d bw=%0d want 0/1", k, if_c.count, if_c.borrow); end
        end
        set_in(0, 0, 0, 0, 4'd0);
        tick();
        total++; if (if_c.borrow !== 1'b0) begin bad++; $display("FAIL sat_pulse_end: got %0d want 0", if_c.borrow); end
    endtask

    task automatic test_priority();
        set_in(0, 1, 0, 0, 4'd3);
        tick();
        set_in(1, 1, 1, 0, 4'd5);
        tick();
        total++; if (if_a.count !== 4'd0) begin bad++; $display("FAIL prio_clr: got %0d want 0", if_a.count); end
        set_in(0, 1, 1, 0, 4'd5);
        tick();
        total++; if (if_a.count !== 4'd5 || if_a.carry !== 1'b0) begin bad++; $display("FAIL prio_load: got cnt=%0d cy=%0d want 5/0", if_a.count, if_a.carry); end
        set_in(0, 0, 0, 0, 4'd0);
    endtask

    task automatic test_random();
        int cnt, cy, bw, mx, mn, shown;
        shown = 0;
        set_in(0, 0, 0, 0, 4'd0);
        rstn = 1'b0;
        model_reset();
        tick();
        rstn = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            set_in($urandom_range(15) == 0, $urandom_range(7) == 0,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));
            tick();
            for (int i = 0; i < NCFG; i++) begin
                int ok;
                read_dut(i, cnt, cy, bw, mx, mn);
                ok = (cnt == m_cnt[i]) && (cy == m_cy[i]) && (bw == m_bw[i]) &&
                     (mx == int'(m_cnt[i] == cfg_mod[i] - 1)) && (mn == int'(m_cnt[i] == 0));
                total++;
                if (ok == 0) begin
                    bad++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL random_cfg%0d_cyc%0d: got cnt=%0d cy=%0d bw=%0d max=%0d min=%0d want cnt=%0d cy=%0d bw=%0d",
                                 i, n, cnt, cy, bw, mx, mn, m_cnt[i], m_cy[i], m_bw[i]);
                    end
                end
            end
        end
        set_in(0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        set_in(0, 0, 0, 0, 4'd0);
        rstn = 1'b1;
        model_reset();
        test_reset();
        test_wrap();
        test_down_priority();
        test_modulus();
        test_saturate();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
